// File: rtl/norm_ctrl.sv
// Post-add/subtract normalization sequencer for the 24-bit floating-point datapath.
// A raw carry+24-bit mantissa is normalized in bounded left-shift steps. The
// exponent is adjusted to match, and zero, underflow and overflow are flagged.
// Both sides use a valid/ready handshake.

// 24-bit leading-zero priority encoder: returns the count of leading zeros,
// or 23 when no bit is set (the all-zero case is resolved before it matters).
module priencoder (
  input  logic [23:0] encoder_in,
  output logic [5:0]  pe_out
);

  // Highest set bit wins: later loop iterations override earlier ones.
  always_comb begin
    pe_out = 6'd23;
    for (int i = 0; i < 24; i++) begin
      if (encoder_in[i]) begin
        pe_out = 6'(23 - i);
      end
    end
  end

endmodule

// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// EVAL  | one cycle: classify operand (zero/overflow/carry/underflow/normal/shift)
// SHIFT | left-shift by up to SHIFT_STEP bits per cycle until rem reaches 0
// DONE  | result presented with out_valid=1, held until out_ready
module norm_ctrl #(
  parameter int EXP_W      = 8,
  parameter int SHIFT_STEP = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_mant,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_uflow,
  output logic             out_oflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Exponents at or above this value overflow when the carry bit bumps them.
  localparam logic [EXP_W:0] OFLOW_TH = (EXP_W+1)'((1 << EXP_W) - 2);
  localparam logic [5:0]     STEP_C   = 6'(SHIFT_STEP);

  state_t           r_state, w_nxt_state;
  logic [24:0]      r_mant,  w_nxt_mant;
  logic [EXP_W-1:0] r_exp,   w_nxt_exp;
  logic             r_sign,  w_nxt_sign;
  logic             r_zero,  w_nxt_zero;
  logic             r_uflow, w_nxt_uflow;
  logic             r_oflow, w_nxt_oflow;
  logic [5:0]       r_rem,   w_nxt_rem;

  logic [5:0]       w_lz;
  logic [EXP_W:0]   w_lz_ext;
  logic [EXP_W:0]   w_exp_ext;
  logic [5:0]       w_k;

  priencoder u_pe (
    .encoder_in (r_mant[23:0]),
    .pe_out     (w_lz)
  );

  assign w_lz_ext  = (EXP_W+1)'(w_lz);
  assign w_exp_ext = {1'b0, r_exp};
  assign w_k       = (r_rem < STEP_C) ? r_rem : STEP_C;

  // State and datapath registers; reset discards any in-flight operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mant  <= '0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_uflow <= 1'b0;
      r_oflow <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_mant  <= w_nxt_mant;
      r_exp   <= w_nxt_exp;
      r_sign  <= w_nxt_sign;
      r_zero  <= w_nxt_zero;
      r_uflow <= w_nxt_uflow;
      r_oflow <= w_nxt_oflow;
      r_rem   <= w_nxt_rem;
    end
  end

  // Next-state and datapath update; all exponent math is done one bit wider.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_mant  = r_mant;
    w_nxt_exp   = r_exp;
    w_nxt_sign  = r_sign;
    w_nxt_zero  = r_zero;
    w_nxt_uflow = r_uflow;
    w_nxt_oflow = r_oflow;
    w_nxt_rem   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_nxt_state = S_EVAL;
          w_nxt_mant  = in_mant;
          w_nxt_exp   = in_exp;
          w_nxt_sign  = in_sign;
          w_nxt_zero  = 1'b0;
          w_nxt_uflow = 1'b0;
          w_nxt_oflow = 1'b0;
          w_nxt_rem   = '0;
        end
      end
      S_EVAL: begin
        w_nxt_state = S_DONE;
        if (r_mant == 25'd0) begin
          w_nxt_zero = 1'b1;
          w_nxt_exp  = '0;
          w_nxt_sign = 1'b0;
        end else if (r_mant[24] && (w_exp_ext >= OFLOW_TH)) begin
          w_nxt_oflow = 1'b1;
          w_nxt_exp   = '1;
          w_nxt_mant  = '0;
        end else if (r_mant[24]) begin
          w_nxt_mant = {1'b0, r_mant[24:1]};
          w_nxt_exp  = EXP_W'(w_exp_ext + (EXP_W+1)'(1));
        end else if (w_lz_ext >= w_exp_ext) begin
          w_nxt_uflow = 1'b1;
          w_nxt_zero  = 1'b1;
          w_nxt_mant  = '0;
          w_nxt_exp   = '0;
          w_nxt_sign  = 1'b0;
        end else if (w_lz != 6'd0) begin
          w_nxt_rem   = w_lz;
          w_nxt_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Bit 24 is clear on this path and k never exceeds the leading-zero
        // count, so no set bit is shifted out.
        w_nxt_mant = {1'b0, r_mant[23:0] << w_k};
        w_nxt_exp  = EXP_W'(w_exp_ext - (EXP_W+1)'(w_k));
        w_nxt_rem  = r_rem - w_k;
        if (r_rem == w_k) begin
          w_nxt_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_mant  = r_mant[23:0];
  assign out_exp   = r_exp;
  assign out_sign  = r_sign;
  assign out_zero  = r_zero;
  assign out_uflow = r_uflow;
  assign out_oflow = r_oflow;

endmodule

// File: tb/tb_norm_ctrl.sv
// Bench for norm_ctrl: three instances (SHIFT_STEP = 24, 4, 1) share one
// stimulus stream; results must match across all three while latency scales
// with the step size.
module tb_norm_ctrl;

  localparam int EXP_W = 8;
  localparam int NI    = 3;

  typedef struct {
    logic [24:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic [23:0] e_mant;
    logic [7:0]  e_exp;
    logic        e_sign;
    logic        e_zero;
    logic        e_uflow;
    logic        e_oflow;
    int          sh;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready, in_sign;
  logic [24:0]      in_mant;
  logic [EXP_W-1:0] in_exp;

  logic             in_ready  [NI];
  logic             out_valid [NI];
  logic             busy      [NI];
  logic             out_sign  [NI];
  logic             out_zero  [NI];
  logic             out_uflow [NI];
  logic             out_oflow [NI];
  logic [23:0]      out_mant  [NI];
  logic [EXP_W-1:0] out_exp   [NI];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    norm_ctrl #(
      .EXP_W      (EXP_W),
      .SHIFT_STEP (g == 0 ? 24 : (g == 1 ? 4 : 1))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_mant   (in_mant),
      .in_exp    (in_exp),
      .in_sign   (in_sign),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_mant  (out_mant[g]),
      .out_exp   (out_exp[g]),
      .out_sign  (out_sign[g]),
      .out_zero  (out_zero[g]),
      .out_uflow (out_uflow[g]),
      .out_oflow (out_oflow[g]),
      .busy      (busy[g])
    );
  end

  function automatic int step_of(input int g);
    return (g == 0) ? 24 : ((g == 1) ? 4 : 1);
  endfunction

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s dut%0d actual=%0h required=%0h", name, g, act, req);
  endtask

  task automatic check_cleared(input string tag);
    for (int g = 0; g < NI; g++) begin
      check({tag, "_valid"}, g, 32'(out_valid[g]), 0);
      check({tag, "_ready"}, g, 32'(in_ready[g]), 1);
      check({tag, "_busy"},  g, 32'(busy[g]), 0);
      check({tag, "_mant"},  g, 32'(out_mant[g]), 0);
      check({tag, "_exp"},   g, 32'(out_exp[g]), 0);
      check({tag, "_sign"},  g, 32'(out_sign[g]), 0);
      check({tag, "_flags"}, g, {29'd0, out_zero[g], out_uflow[g], out_oflow[g]}, 0);
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    for (int g = 0; g < NI; g++) begin
      check({tag, "_valid"}, g, 32'(out_valid[g]), 1);
      check({tag, "_mant"},  g, 32'(out_mant[g]), 32'(v.e_mant));
      check({tag, "_exp"},   g, 32'(out_exp[g]), 32'(v.e_exp));
      check({tag, "_sign"},  g, 32'(out_sign[g]), 32'(v.e_sign));
      check({tag, "_zero"},  g, 32'(out_zero[g]), 32'(v.e_zero));
      check({tag, "_uflow"}, g, 32'(out_uflow[g]), 32'(v.e_uflow));
      check({tag, "_oflow"}, g, 32'(out_oflow[g]), 32'(v.e_oflow));
      if (out_valid[g] && !out_zero[g] && !out_oflow[g])
        check({tag, "_msb"}, g, 32'(out_mant[g][23]), 1);
    end
  endtask

  // Apply one operand, measure latency per instance, check, optionally hold
  // backpressure for 5 cycles, then release.
  task automatic run_vec(input string tag, input vec_t v, input bit bp);
    int  lat [NI];
    bit  all_done;
    for (int g = 0; g < NI; g++) begin
      lat[g] = 0;
      check({tag, "_idle"}, g, 32'(in_ready[g]), 1);
    end
    in_mant  = v.mant;
    in_exp   = v.exp;
    in_sign  = v.sign;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mant  = 25'h1555555;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      all_done = 1'b1;
      for (int g = 0; g < NI; g++) begin
        if (out_valid[g] && lat[g] == 0) lat[g] = c;
        if (lat[g] == 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    for (int g = 0; g < NI; g++) begin
      int st = step_of(g);
      int req_lat = (v.sh == 0) ? 1 : 1 + (v.sh + st - 1) / st;
      check({tag, "_latency"}, g, 32'(lat[g]), 32'(req_lat));
    end
    check_result(tag, v);
    if (bp) begin
      for (int c = 0; c < 5; c++) begin
        in_valid = 1'b1;
        in_mant  = 25'(32'h0000F00 + c);
        in_exp   = 8'(c + 3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int g = 0; g < NI; g++) check({tag, "_bp_ready"}, g, 32'(in_ready[g]), 0);
        check_result({tag, "_bp"}, v);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check({tag, "_rel_valid"}, g, 32'(out_valid[g]), 0);
      check({tag, "_rel_ready"}, g, 32'(in_ready[g]), 1);
    end
  endtask

  vec_t vecs [13];

  initial begin
    //           mant          exp     s     e_mant       e_exp   s  z  u  o  sh
    vecs[0]  = '{25'h0000100, 8'd100, 1'b1, 24'h800000, 8'd85,  1, 0, 0, 0, 15};
    vecs[1]  = '{25'h0800000, 8'd50,  1'b0, 24'h800000, 8'd50,  0, 0, 0, 0, 0};
    vecs[2]  = '{25'h1800000, 8'd10,  1'b0, 24'hC00000, 8'd11,  0, 0, 0, 0, 0};
    vecs[3]  = '{25'h1000000, 8'd254, 1'b1, 24'h000000, 8'd255, 1, 0, 0, 1, 0};
    vecs[4]  = '{25'h0000000, 8'd77,  1'b1, 24'h000000, 8'd0,   0, 1, 0, 0, 0};
    vecs[5]  = '{25'h0000001, 8'd20,  1'b0, 24'h000000, 8'd0,   0, 1, 1, 0, 0};
    vecs[6]  = '{25'h0000001, 8'd30,  1'b1, 24'h800000, 8'd7,   1, 0, 0, 0, 23};
    vecs[7]  = '{25'h1FFFFFF, 8'd253, 1'b0, 24'hFFFFFF, 8'd254, 0, 0, 0, 0, 0};
    vecs[8]  = '{25'h0123456, 8'd40,  1'b1, 24'h91A2B0, 8'd37,  1, 0, 0, 0, 3};
    vecs[9]  = '{25'h0400000, 8'd1,   1'b0, 24'h000000, 8'd0,   0, 1, 1, 0, 0};
    vecs[10] = '{25'h0400000, 8'd2,   1'b0, 24'h800000, 8'd1,   0, 0, 0, 0, 1};
    vecs[11] = '{25'h0800000, 8'd0,   1'b1, 24'h000000, 8'd0,   0, 1, 1, 0, 0};
    vecs[12] = '{25'h1000000, 8'd253, 1'b1, 24'h800000, 8'd254, 1, 0, 0, 0, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    in_sign   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], (i == 8));
    end

    // Reset during the 3rd SHIFT cycle of the step-1 instance; the concurrent
    // in_valid must be ignored.
    in_mant  = 25'h0000100;
    in_exp   = 8'd100;
    in_sign  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_busy", 2, 32'(busy[2]), 1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_mant  = 25'h0800000;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_cleared("midrst");
    @(posedge clk); #1;
    check_cleared("midrst_hold");
    run_vec("after_rst", vecs[0], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
